// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: FSM state encodings and flag bit positions shared by the serial subtractor.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        SS_IDLE  = 2'd0,
        SS_SHIFT = 2'd1,
        SS_DONE  = 2'd2
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake and operand/result bus; flags exist only with SERIAL_SUB_FLAGS_EN.
interface serial_subtractor_if #(parameter int WIDTH = 64);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUB_FLAGS_EN
    logic [3:0]       flags;
    modport master (output start, a, b, input busy, done, diff, borrow, flags);
    modport slave  (input start, a, b, output busy, done, diff, borrow, flags);
`else
    modport master (output start, a, b, input busy, done, diff, borrow);
    modport slave  (input start, a, b, output busy, done, diff, borrow);
`endif
endinterface

// File: rtl/serial_subtractor_fs.sv
// full_subtractor: 1-bit gate-level subtractor cell, diff = a ^ b ^ b_in with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic diff,
    output logic b_out
);
    logic x, na, nx, t_ab, t_br;
    xor g_x    (x, a, b);
    xor g_d    (diff, x, b_in);
    not g_na   (na, a);
    not g_nx   (nx, x);
    and g_ab   (t_ab, na, b);
    and g_br   (t_br, nx, b_in);
    or  g_bout (b_out, t_ab, t_br);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b using one full_subtractor and a borrow flip-flop.
// Optional NZCV flags are built when SERIAL_SUB_FLAGS_EN is defined.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input logic                clk,
    input logic                rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    state_t           state, state_n;
    logic [WIDTH-1:0] a_sh, b_sh, res, res_n, diff_q;
    logic [CW-1:0]    cnt;
    logic             br, d, bo, borrow_q, accept, last;

    // DONE is not busy, so a start there chains straight into the next operation
    assign accept = bus.start && state != SS_SHIFT;
    assign last   = state == SS_SHIFT && cnt == CW'(WIDTH - 1);
    assign res_n  = {d, res[WIDTH-1:1]};

    full_subtractor u_fs (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .b_in (br),
        .diff (d),
        .b_out(bo)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= SS_IDLE;
        else        state <= state_n;

    always_comb begin
        state_n = state;
        state_n = accept ? SS_SHIFT :
                  last ? SS_DONE :
                  state == SS_DONE ? SS_IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res      <= '0;
            cnt      <= '0;
            br       <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else if (accept) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
            cnt  <= '0;
            br   <= 1'b0;
        end else if (state == SS_SHIFT) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            res  <= res_n;
            br   <= bo;
            cnt  <= cnt + CW'(1);
            if (last) begin
                diff_q   <= res_n;
                borrow_q <= bo;
            end
        end

    assign bus.busy   = state == SS_SHIFT;
    assign bus.done   = state == SS_DONE;
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;

`ifdef SERIAL_SUB_FLAGS_EN
    logic       a_msb, b_msb;
    logic [3:0] flags_q;

    // operand sign bits are shifted out during the op, so keep copies for V
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            flags_q <= '0;
        end else if (accept) begin
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
        end else if (last) begin
            flags_q[FLAG_N] <= res_n[WIDTH-1];
            flags_q[FLAG_Z] <= res_n == '0;
            flags_q[FLAG_C] <= ~bo;
            flags_q[FLAG_V] <= (a_msb != b_msb) && (res_n[WIDTH-1] != a_msb);
        end

    assign bus.flags = flags_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: table-driven and randomized checks of the 8-bit serial subtractor against an arithmetic model.
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    serial_subtractor_if #(.WIDTH(W)) bus ();
    serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       borrow;
        logic [3:0] flags;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] model_flags(input logic [7:0] x, input logic [7:0] y);
        int sd;
        logic [7:0] dd;
        sd = $signed(x) - $signed(y);
        dd = x - y;
        return {dd[7], dd == 8'h00, x >= y, (sd > 127 || sd < -128)};
    endfunction

    task automatic check_flags(input string name, input logic [3:0] exp);
`ifdef SERIAL_SUB_FLAGS_EN
        chk(name, {28'd0, bus.flags}, {28'd0, exp});
`endif
    endtask

    task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic [7:0] ed,
                         input logic eb, input logic [3:0] ef);
        int cyc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = x;
        bus.b = y;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        chk("busy", {31'd0, bus.busy}, 32'd1);
        while (!bus.done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, 9);
        chk("diff", {24'd0, bus.diff}, {24'd0, ed});
        chk("borrow", {31'd0, bus.borrow}, {31'd0, eb});
        check_flags("flags", ef);
        @(negedge clk);
        chk("done_pulse", {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int ndone;
        int done_cyc[2];
        logic [7:0] done_diff[2];
        logic [7:0] x, y;
        tbl[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 4'b0010};
        tbl[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 4'b1000};
        tbl[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 4'b0011};
        tbl[3] = '{8'h42, 8'h42, 8'h00, 1'b0, 4'b0110};
        tbl[4] = '{8'h00, 8'h01, 8'hFF, 1'b1, 4'b1000};
        tbl[5] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 4'b0110};
        tbl[6] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 4'b1001};
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_diff", {24'd0, bus.diff}, 32'd0);
        chk("rst_borrow", {31'd0, bus.borrow}, 32'd0);
        check_flags("rst_flags", 4'd0);
        rst_n = 1'b1;

        foreach (tbl[i]) do_op(tbl[i].a, tbl[i].b, tbl[i].diff, tbl[i].borrow, tbl[i].flags);

        for (int i = 0; i < 40; i++) begin
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            do_op(x, y, 8'((int'(x) - int'(y) + 256) % 256), x < y, model_flags(x, y));
        end

        // start pulses while shifting are ignored
        ndone = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'h10;
        bus.b = 8'h01;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            bus.start = (cyc == 3 || cyc == 5);
            bus.a = 8'hFF;
            bus.b = 8'h00;
            if (bus.done) begin
                if (ndone < 2) begin
                    done_cyc[ndone] = cyc;
                    done_diff[ndone] = bus.diff;
                end
                ndone++;
            end
        end
        chk("ign_ndone", ndone, 1);
        chk("ign_cycle", done_cyc[0], 9);
        chk("ign_diff", {24'd0, done_diff[0]}, 32'h0F);

        // start held across DONE chains a second operation
        ndone = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'h20;
        bus.b = 8'h05;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            @(negedge clk);
            if (bus.done) begin
                if (ndone < 2) begin
                    done_cyc[ndone] = cyc;
                    done_diff[ndone] = bus.diff;
                end
                ndone++;
            end
            if (cyc == 9) begin
                bus.a = 8'h05;
                bus.b = 8'h20;
            end
            if (cyc == 10) bus.start = 1'b0;
        end
        chk("b2b_ndone", ndone, 2);
        chk("b2b_cycle0", done_cyc[0], 9);
        chk("b2b_cycle1", done_cyc[1], 18);
        chk("b2b_diff0", {24'd0, done_diff[0]}, 32'h1B);
        chk("b2b_diff1", {24'd0, done_diff[1]}, 32'hE5);
        chk("b2b_borrow", {31'd0, bus.borrow}, 32'd1);

        // asynchronous reset mid-operation discards the op
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 8'h33;
        bus.b = 8'h11;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        chk("arst_done", {31'd0, bus.done}, 32'd0);
        chk("arst_diff", {24'd0, bus.diff}, 32'd0);
        chk("arst_borrow", {31'd0, bus.borrow}, 32'd0);
        check_flags("arst_flags", 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("arst_nodone", ndone, 0);

        do_op(8'h05, 8'h03, 8'h02, 1'b0, 4'b0010);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
